throughout_seq_gen: RTL and testbench

Synthesizable stimulus generator that produces the guarded-event pattern checked by the `throughout`/`or`/`first_match` assertion benches. It accepts one command at a time over a valid/ready handshake. For each command it holds the guard line `transport` high for a programmed window and raises `bus`, `train`, or both inside that window. It sits on the driving side of an assertion checker, so pass and fail cases can be produced cycle-exactly instead of with hand-timed `#` delays.

---
 rtl/throughout_gen_pkg.sv | 19 +
 rtl/tg_cycle_counter.sv | 27 ++
 rtl/throughout_seq_gen.sv | 129 ++++++++++++
 tb/tb_throughout_seq_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/throughout_gen_pkg.sv
// Shared types and constants for the guarded-event stimulus generator.
package throughout_gen_pkg;

    localparam int LEAD_W_DEF = 4;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        EVENT = 2'd2,
        DONE  = 2'd3
    } gen_state_e;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_BUS   = 2'b01;
    localparam logic [1:0] SEL_TRAIN = 2'b10;
    localparam logic [1:0] SEL_BOTH  = 2'b11;

endpackage

// File: rtl/tg_cycle_counter.sv
// Loadable down-counter; tc flags the last cycle of a loaded interval (count == 1).
module tg_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Parks at zero once an interval has elapsed, so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == W'(1));

endmodule

// File: rtl/throughout_seq_gen.sv
// Guard/event window generator for throughout-style assertion stimulus.
// Optional macro THROUGHOUT_ERR_INJ_EN adds cmd_inj to drop the guard in the last event cycle.
//
//   state | meaning
//   IDLE  | ready for a command, all lines low
//   LEAD  | guard high, events low, counting lead cycles
//   EVENT | guard high, selected events high, counting len' cycles
//   DONE  | one-cycle done pulse, not ready
module throughout_seq_gen
    import throughout_gen_pkg::*;
#(
    parameter int LEAD_W = LEAD_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_sel,
    input  logic [LEAD_W-1:0] cmd_lead,
    input  logic [LEN_W-1:0]  cmd_len,
`ifdef THROUGHOUT_ERR_INJ_EN
    input  logic              cmd_inj,
`endif
    output logic              transport,
    output logic              bus,
    output logic              train,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (LEAD_W > LEN_W) ? LEAD_W : LEN_W;

    gen_state_e       state_q, state_d;
    logic [1:0]       sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic             fire;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;
    logic             inj_drop;

    assign fire    = cmd_valid && (state_q == IDLE);
    assign len_eff = (cmd_len == '0) ? LEN_W'(1) : cmd_len;

    tg_cycle_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_NONE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                sel_q <= cmd_sel;
                len_q <= len_eff;
            end
        end
    end

`ifdef THROUGHOUT_ERR_INJ_EN
    logic inj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q <= 1'b0;
        end else if (fire) begin
            inj_q <= cmd_inj;
        end
    end

    assign inj_drop = inj_q && cnt_tc;
`else
    assign inj_drop = 1'b0;
`endif

    // Counter is only ever loaded on entry to LEAD or EVENT.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    cnt_load = 1'b1;
                    if (cmd_lead != '0) begin
                        state_d = LEAD;
                        cnt_val = CNT_W'(cmd_lead);
                    end else begin
                        state_d = EVENT;
                        cnt_val = CNT_W'(len_eff);
                    end
                end
            end
            LEAD: begin
                if (cnt_tc) begin
                    state_d  = EVENT;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(len_q);
                end
            end
            EVENT: begin
                if (cnt_tc) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        transport = (state_q == LEAD) || ((state_q == EVENT) && !inj_drop);
        bus       = (state_q == EVENT) && ((sel_q == SEL_BUS) || (sel_q == SEL_BOTH));
        train     = (state_q == EVENT) && ((sel_q == SEL_TRAIN) || (sel_q == SEL_BOTH));
    end

endmodule

// File: tb/tb_throughout_seq_gen.sv
// Bench for throughout_seq_gen: table of commands, corner sequences and random traffic vs. a window model.
module tb_throughout_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [3:0] cmd_lead;
    logic [3:0] cmd_len;
`ifdef THROUGHOUT_ERR_INJ_EN
    logic       cmd_inj;
`endif
    logic       transport, bus, train, busy, done;

    throughout_seq_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_lead  (cmd_lead),
        .cmd_len   (cmd_len),
`ifdef THROUGHOUT_ERR_INJ_EN
        .cmd_inj   (cmd_inj),
`endif
        .transport (transport),
        .bus       (bus),
        .train     (train),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model of the current window: accepted at edge m_k with given lead and effective length.
    int         cyc = 0;
    bit         m_act = 1'b0;
    int         m_k, m_lead, m_lenp;
    logic [1:0] m_sel;
`ifdef THROUGHOUT_ERR_INJ_EN
    bit         m_inj;
`endif
    logic [5:0] obs;

    // Returns {cmd_ready, transport, bus, train, busy, done} for the cycle after edge t.
    function automatic logic [5:0] model_out(input int t);
        int d, l;
        bit tr, ev, dn, rdy;
        if (!m_act) return 6'b100000;
        d   = t - m_k;
        l   = m_lead + m_lenp;
        tr  = (d >= 0) && (d < l);
        ev  = (d >= m_lead) && (d < l);
`ifdef THROUGHOUT_ERR_INJ_EN
        if (m_inj && d == l - 1) tr = 1'b0;
`endif
        dn  = (d == l);
        rdy = (d > l);
        return {rdy, tr, ev && m_sel[0], ev && m_sel[1], !rdy, dn};
    endfunction

    function automatic void check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endfunction

    task automatic step(input bit v, input logic [1:0] s, input logic [3:0] ld,
                        input logic [3:0] ln, input bit ij);
        bit         rp;
        logic [5:0] e;
        rp        = model_out(cyc)[5];
        cmd_valid = v;
        cmd_sel   = s;
        cmd_lead  = ld;
        cmd_len   = ln;
`ifdef THROUGHOUT_ERR_INJ_EN
        cmd_inj   = ij;
`endif
        @(posedge clk);
        cyc++;
        if (v && rp) begin
            m_act  = 1'b1;
            m_k    = cyc;
            m_lead = int'(ld);
            m_lenp = (ln == 4'd0) ? 1 : int'(ln);
            m_sel  = s;
`ifdef THROUGHOUT_ERR_INJ_EN
            m_inj  = ij;
`endif
        end
        @(negedge clk);
        e   = model_out(cyc);
        obs = {cmd_ready, transport, bus, train, busy, done};
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL cycle_check cyc=%0d got=%b exp=%b (ready,transport,bus,train,busy,done)",
                     cyc, obs, e);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [3:0] lead;
        logic [3:0] len;
        bit         inj;
        int         n_tr;
        int         n_bus;
        int         n_train;
        int         n_done;
        int         n_busy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n, c_tr, c_bus, c_train, c_done, c_busy;

        vecs.push_back('{2'b01, 4'd2,  4'd3,  1'b0, 5,  3,  0,  1, 6});
        vecs.push_back('{2'b10, 4'd0,  4'd0,  1'b0, 1,  0,  1,  1, 2});
        vecs.push_back('{2'b00, 4'd1,  4'd2,  1'b0, 3,  0,  0,  1, 4});
        vecs.push_back('{2'b11, 4'd0,  4'd15, 1'b0, 15, 15, 15, 1, 16});
        vecs.push_back('{2'b11, 4'd15, 4'd1,  1'b0, 16, 1,  1,  1, 17});
        vecs.push_back('{2'b01, 4'd3,  4'd0,  1'b0, 4,  1,  0,  1, 5});
`ifdef THROUGHOUT_ERR_INJ_EN
        vecs.push_back('{2'b01, 4'd1,  4'd3,  1'b1, 3,  3,  0,  1, 5});
`endif

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = 2'b00;
        cmd_lead  = 4'd0;
        cmd_len   = 4'd0;
`ifdef THROUGHOUT_ERR_INJ_EN
        cmd_inj   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({cmd_ready, transport, bus, train, busy, done}), 32);
        rst_n = 1'b1;

        // Table: one command each, summary counts over the whole window.
        for (int i = 0; i < vecs.size(); i++) begin
            c_tr = 0; c_bus = 0; c_train = 0; c_done = 0; c_busy = 0;
            step(1'b1, vecs[i].sel, vecs[i].lead, vecs[i].len, vecs[i].inj);
            n = 1;
            while (!obs[5] && n < 40) begin
                c_tr    += int'(obs[4]);
                c_bus   += int'(obs[3]);
                c_train += int'(obs[2]);
                c_busy  += int'(obs[1]);
                c_done  += int'(obs[0]);
                step(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
                n++;
            end
            check($sformatf("vec%0d_ready_returned", i), int'(obs[5]), 1);
            check($sformatf("vec%0d_transport_cycles", i), c_tr, vecs[i].n_tr);
            check($sformatf("vec%0d_bus_cycles", i), c_bus, vecs[i].n_bus);
            check($sformatf("vec%0d_train_cycles", i), c_train, vecs[i].n_train);
            check($sformatf("vec%0d_done_pulses", i), c_done, vecs[i].n_done);
            check($sformatf("vec%0d_busy_cycles", i), c_busy, vecs[i].n_busy);
        end

        // cmd_valid held high: windows of 2 every 4 cycles.
        c_done = 0; c_tr = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'b11, 4'd1, 4'd1, 1'b0);
            c_done += int'(obs[0]);
            c_tr   += int'(obs[4]);
        end
        check("b2b_done_pulses", c_done, 3);
        check("b2b_transport_cycles", c_tr, 6);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);

        // Reset in the middle of an EVENT phase.
        step(1'b1, 2'b01, 4'd0, 4'd8, 1'b0);
        step(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
        step(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
        check("pre_reset_bus", int'(bus), 1);
        rst_n = 1'b0;
        m_act = 1'b0;
        #1;
        check("mid_reset_outputs", int'({cmd_ready, transport, bus, train, busy, done}), 32);
        @(negedge clk);
        rst_n = 1'b1;
        c_done = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
            c_done += int'(obs[0]);
        end
        check("post_reset_no_done", c_done, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4)),
                 ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4)),
                 $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
